// File: rtl/ysyx_22041211_div_unit_pkg.sv
// Shared definitions for the iterative divider.
// Contents: the RV32M divide opcode encoding, the divider FSM state
// encoding, and helpers that decode the opcode.
package ysyx_22041211_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // DIV and REM are signed. Their encodings are the ones with bit 0 clear.
  function automatic logic is_signed_op(input div_op_e op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder. Their encodings are the ones with bit 1 set.
  function automatic logic is_rem_op(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/ysyx_22041211_div_unit_if.sv
// Request/response channel between the execute stage and the divider.
// master : the execute stage (drives the request, flush and result_ready)
// slave  : the divider (drives div_ready_o, result_valid_o and result_o)
// Signal names keep the divider-side _i/_o suffixes, so both ends read alike.
interface ysyx_22041211_div_unit_if
  import ysyx_22041211_div_unit_pkg::*;
#(
  parameter int DATA_LEN = 32
);
  logic                div_valid_i;
  logic                div_ready_o;
  div_op_e             div_op_i;
  logic [DATA_LEN-1:0] src1;
  logic [DATA_LEN-1:0] src2;
  logic                flush_i;
  logic                result_valid_o;
  logic                result_ready_i;
  logic [DATA_LEN-1:0] result_o;

  modport master (
    output div_valid_i, div_op_i, src1, src2, flush_i, result_ready_i,
    input  div_ready_o, result_valid_o, result_o
  );

  modport slave (
    input  div_valid_i, div_op_i, src1, src2, flush_i, result_ready_i,
    output div_ready_o, result_valid_o, result_o
  );
endinterface

// File: rtl/ysyx_22041211_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// i_rem/i_quo : partial remainder and dividend/quotient shift register
// i_divisor   : divisor magnitude
// o_rem/o_quo : values after the shift, the trial subtract and the restore
module ysyx_22041211_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);
  logic [W:0]   w_shifted;
  logic [W+1:0] w_sum;
  logic         w_no_borrow;

  // Shift {rem,quo} left by one. The MSB of quo moves into the remainder.
  assign w_shifted = {i_rem, i_quo[W-1]};

  // 33-bit subtract, done as an add of the inverted operand plus one.
  // A carry-out of 1 means no borrow, so the divisor fits.
  assign w_sum       = {1'b0, w_shifted} + {1'b0, ~{1'b0, i_divisor}} + {{(W+1){1'b0}}, 1'b1};
  assign w_no_borrow = w_sum[W+1];

  // The remainder stays below the divisor, so the low W bits hold all of it.
  assign o_rem = w_no_borrow ? w_sum[W-1:0] : w_shifted[W-1:0];
  assign o_quo = {i_quo[W-2:0], w_no_borrow};
endmodule

// File: rtl/ysyx_22041211_div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// clock, reset : rising-edge clock; asynchronous active-high reset
// bus          : request (div_valid_i/div_ready_o, op, src1, src2), flush_i,
//                and response (result_valid_o/result_ready_i, result_o)
// A normal op takes 32 CALC cycles. Division by zero and signed overflow
// skip CALC and go straight to DONE with the architected result.
module ysyx_22041211_div_unit
  import ysyx_22041211_div_unit_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int CNT_W    = 5
) (
  input logic                      clock,
  input logic                      reset,
  ysyx_22041211_div_unit_if.slave  bus
);
  div_state_e          r_state, w_next_state;
  div_op_e             r_op;
  logic [DATA_LEN-1:0] r_rem, r_quo, r_dvsr, r_result;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_q, r_neg_r;

  logic                w_accept, w_signed, w_rem_sel, w_a_neg, w_b_neg;
  logic                w_div0, w_ovf, w_special, w_last, w_leave_done;
  logic [DATA_LEN-1:0] w_a_mag, w_b_mag, w_special_res;
  logic [DATA_LEN-1:0] w_step_rem, w_step_quo, w_final;

  localparam logic [DATA_LEN-1:0] INT_MIN = {1'b1, {(DATA_LEN-1){1'b0}}};

  assign w_accept  = (r_state == ST_IDLE) && bus.div_valid_i && !bus.flush_i;
  assign w_signed  = is_signed_op(bus.div_op_i);
  assign w_rem_sel = is_rem_op(bus.div_op_i);
  assign w_a_neg   = w_signed && bus.src1[DATA_LEN-1];
  assign w_b_neg   = w_signed && bus.src2[DATA_LEN-1];
  assign w_a_mag   = w_a_neg ? -bus.src1 : bus.src1;
  assign w_b_mag   = w_b_neg ? -bus.src2 : bus.src2;
  assign w_div0    = (bus.src2 == '0);
  assign w_ovf     = w_signed && (bus.src1 == INT_MIN) && (&bus.src2);
  assign w_special = w_div0 || w_ovf;

  // RISC-V results for operations that need no iteration.
  assign w_special_res = w_div0 ? (w_rem_sel ? bus.src1 : '1)
                                : (w_rem_sel ? '0 : INT_MIN);

  assign w_last       = (r_cnt == CNT_W'(DATA_LEN - 1));
  assign w_leave_done = bus.flush_i || bus.result_ready_i;

  ysyx_22041211_div_step #(.W(DATA_LEN)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvsr),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // Sign fix-up uses the final step's outputs, so DONE shows the finished result.
  // The quotient is negative when the operand signs differ.
  // The remainder takes the sign of the dividend.
  assign w_final = is_rem_op(r_op) ? (r_neg_r ? -w_step_rem : w_step_rem)
                                   : (r_neg_q ? -w_step_quo : w_step_quo);

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // values from before the edge, whatever order the blocks are evaluated in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: the default assignment comes first, so no path leaves w_next_state
  // unassigned. That keeps this block purely combinational, with no latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next_state = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (bus.flush_i) w_next_state = ST_IDLE;
               else if (w_last) w_next_state = ST_DONE;
      ST_DONE: if (w_leave_done) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op     <= DIV_OP_DIV;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= bus.div_op_i;
          r_rem   <= '0;
          r_quo   <= w_a_mag;
          r_dvsr  <= w_b_mag;
          r_cnt   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          if (w_special) r_result <= w_special_res;
        end
        ST_CALC: if (!bus.flush_i) begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_result <= w_final;
        end
        // Clear the result on leaving DONE, so result_o reads 0 when no result is held.
        ST_DONE: if (w_leave_done) r_result <= '0;
        default: ;
      endcase
    end
  end

  assign bus.div_ready_o    = (r_state == ST_IDLE);
  assign bus.result_valid_o = (r_state == ST_DONE);
  assign bus.result_o       = r_result;
endmodule

// File: tb/tb_ysyx_22041211_div_unit.sv
// Directed testbench for ysyx_22041211_div_unit. A plain-arithmetic RV32M
// model supplies the expected result of each op. Literal vectors pin that
// model, and a compare process checks every cycle in which a result is valid.
module tb_ysyx_22041211_div_unit;
  import ysyx_22041211_div_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ysyx_22041211_div_unit_if #(.DATA_LEN(32)) bus ();

  ysyx_22041211_div_unit #(.DATA_LEN(32), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // RV32M semantics written directly from the ISA rules.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) begin
      sa = $signed(a);
      sb = $signed(b);
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // While a result is valid, it must match the model and no new request may be accepted.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.result_valid_o === 1'b1) begin
      check("result_vs_model", bus.result_o, exp_model);
      check("ready_low_in_done", {31'b0, bus.div_ready_o}, 32'd0);
    end
  end

  // Issue one op and wait for its result. The latency is counted in clock
  // edges after the accept edge: 32 for a normal op, 0 for a special op,
  // whose result is valid in the first cycle after the accept.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int lat_exp,
                        input int hold);
    int lat;
    bit seen;
    @(negedge clock);
    bus.div_op_i    = div_op_e'(op);
    bus.src1        = a;
    bus.src2        = b;
    bus.div_valid_i = 1'b1;
    exp_model       = model(op, a, b);
    check({name, "_model"}, exp_model, lit);
    @(posedge clock);
    #1;
    bus.div_valid_i = 1'b0;
    bus.src1        = $urandom;
    bus.src2        = $urandom;
    bus.div_op_i    = div_op_e'(2'($urandom));
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.result_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock);
      lat++;
    end
    check({name, "_valid_seen"}, {31'b0, seen}, 32'd1);
    check({name, "_latency"}, lat, lat_exp);
    check({name, "_result"}, bus.result_o, lit);
    // Hold the result back while a new request is offered. The request must be ignored.
    for (int i = 0; i < hold; i++) begin
      bus.div_valid_i = 1'b1;
      bus.src1        = 32'd7;
      bus.src2        = 32'd3;
      @(posedge clock);
      @(negedge clock);
      check({name, "_hold_valid"}, {31'b0, bus.result_valid_o}, 32'd1);
      check({name, "_hold_result"}, bus.result_o, lit);
    end
    bus.div_valid_i    = 1'b0;
    bus.result_ready_i = 1'b1;
    @(posedge clock);
    #1;
    bus.result_ready_i = 1'b0;
    check({name, "_valid_drop"}, {31'b0, bus.result_valid_o}, 32'd0);
    check({name, "_ready_back"}, {31'b0, bus.div_ready_o}, 32'd1);
  endtask

  initial begin
    int pulses;
    bus.div_valid_i    = 1'b0;
    bus.div_op_i       = DIV_OP_DIV;
    bus.src1           = '0;
    bus.src2           = '0;
    bus.flush_i        = 1'b0;
    bus.result_ready_i = 1'b0;

    // Assert reset before the first clock edge and check the outputs at once.
    #1 reset = 1'b1;
    #2;
    check("reset_ready",  {31'b0, bus.div_ready_o},    32'd1);
    check("reset_valid",  {31'b0, bus.result_valid_o}, 32'd0);
    check("reset_result", bus.result_o,                32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    //     name          op     src1          src2          expected      lat hold
    run_op("div_20_m3",   2'b00, 32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, 32, 0);
    run_op("rem_20_m3",   2'b10, 32'd20,       32'hFFFF_FFFD, 32'h0000_0002, 32, 0);
    run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32, 0);
    run_op("remu_m7_2",   2'b11, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32, 0);
    run_op("divu_by0",    2'b01, 32'd5,        32'd0,        32'hFFFF_FFFF, 0,  0);
    run_op("remu_by0",    2'b11, 32'd5,        32'd0,        32'h0000_0005, 0,  0);
    run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  0);
    run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0,  0);
    run_op("divu_hold",   2'b01, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 32, 5);
    run_op("div_zero_dd", 2'b00, 32'd0,        32'd7,        32'h0000_0000, 32, 0);
    run_op("div_m100_7",  2'b00, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32, 0);
    run_op("rem_m100_7",  2'b10, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 32, 0);
    run_op("rem_m5_by0",  2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 0,  0);
    run_op("divu_big",    2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32, 0);
    run_op("remu_big",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 0);

    // A flush after 10 CALC steps returns to IDLE on the next edge, and no result appears.
    @(negedge clock);
    bus.div_op_i = DIV_OP_DIVU; bus.src1 = 32'd100; bus.src2 = 32'd7;
    bus.div_valid_i = 1'b1;
    @(posedge clock);
    #1 bus.div_valid_i = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    bus.flush_i = 1'b1;
    @(posedge clock);
    #1 bus.flush_i = 1'b0;
    check("flush_calc_ready", {31'b0, bus.div_ready_o},    32'd1);
    check("flush_calc_valid", {31'b0, bus.result_valid_o}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.result_valid_o) pulses++;
    end
    check("flush_no_result", pulses, 32'd0);

    // A flush in IDLE blocks the accept, even for a request that would finish in one cycle.
    @(negedge clock);
    bus.div_op_i = DIV_OP_DIVU; bus.src1 = 32'd5; bus.src2 = 32'd0;
    bus.div_valid_i = 1'b1;
    bus.flush_i     = 1'b1;
    @(posedge clock);
    #1;
    bus.div_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    check("flush_idle_ready", {31'b0, bus.div_ready_o},    32'd1);
    check("flush_idle_valid", {31'b0, bus.result_valid_o}, 32'd0);

    // A flush in DONE discards the result, even with result_ready_i also high.
    @(negedge clock);
    bus.div_op_i = DIV_OP_REMU; bus.src1 = 32'd9; bus.src2 = 32'd0;
    bus.div_valid_i = 1'b1;
    exp_model = model(2'b11, 32'd9, 32'd0);
    @(posedge clock);
    #1 bus.div_valid_i = 1'b0;
    @(negedge clock);
    check("flush_done_pre", {31'b0, bus.result_valid_o}, 32'd1);
    bus.flush_i        = 1'b1;
    bus.result_ready_i = 1'b1;
    @(posedge clock);
    #1;
    bus.flush_i        = 1'b0;
    bus.result_ready_i = 1'b0;
    check("flush_done_valid", {31'b0, bus.result_valid_o}, 32'd0);

    // An asynchronous reset in the middle of CALC takes effect before the next clock edge.
    @(negedge clock);
    bus.div_op_i = DIV_OP_DIV; bus.src1 = 32'd100; bus.src2 = 32'd7;
    bus.div_valid_i = 1'b1;
    exp_model = model(2'b00, 32'd100, 32'd7);
    @(posedge clock);
    #1 bus.div_valid_i = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #2;
    check("areset_ready",  {31'b0, bus.div_ready_o},    32'd1);
    check("areset_valid",  {31'b0, bus.result_valid_o}, 32'd0);
    check("areset_result", bus.result_o,                32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Normal operation resumes after the reset.
    run_op("div_after_rst", 2'b00, 32'd100, 32'd7, 32'h0000_000E, 32, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
